pbbounce_gen: RTL

Synthesizable push-button bounce emulator: the transmit-side counterpart of `pbdebounce`. On a request it drives a noisy `button` line from its current level to a target level with a programmable number of glitches, then holds the clean level through a settle window. It feeds `pbdebounce` in self-test builds and in board bring-up, where a real switch is absent.

---
 rtl/pbbounce_pkg.sv | 22 ++
 rtl/pbbounce_gen_lfsr16.sv | 26 ++
 rtl/pbbounce_gen.sv | 117 +++++++++++
 3 files changed

// File: rtl/pbbounce_pkg.sv
// rtl/pbbounce_pkg.sv - shared types and constants for the push-button bounce emulator
package pbbounce_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // Right-shifting Fibonacci taps for x^16+x^14+x^13+x^11+1 (bits 0,2,3,5)
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Default LFSR seed
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // One LFSR step: feedback is the parity of the tapped bits, shifted in at the top
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/pbbounce_gen_lfsr16.sv
// rtl/pbbounce_gen_lfsr16.sv - free-running 16-bit Fibonacci LFSR with zero-seed guard
module lfsr16
    import pbbounce_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      seed,
    output logic [OUT_W-1:0] value
);

    logic [15:0] state;

    // Advance every cycle; a zero seed would lock the register, so it becomes 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else begin
            state <= lfsr_next(state);
        end
    end

    assign value = state[OUT_W-1:0];

endmodule

// File: rtl/pbbounce_gen.sv
// rtl/pbbounce_gen.sv - push-button bounce emulator (PBBOUNCE_FIXED_GAP_EN selects fixed gaps)
module pbbounce_gen
    import pbbounce_pkg::*;
#(
    parameter int          BOUNCE_MAX = 7,
    parameter int          GAP_W      = 8,
    parameter int          FIX_GAP    = 4,
    parameter int          SETTLE_CYC = 64,
    parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       level,
    input  logic [2:0] bounces,
    output logic       button,
    output logic       busy,
    output logic       done
);

    // One down-counter serves both the gap and the settle window
    localparam int FIX_W  = $clog2(FIX_GAP + 1);
    localparam int SET_W  = $clog2(SETTLE_CYC + 1);
    localparam int GAP_CW = (GAP_W > FIX_W) ? GAP_W : FIX_W;
    localparam int CNT_W  = (GAP_CW > SET_W) ? GAP_CW : SET_W;
    localparam int TGL_RW = $clog2(2 * BOUNCE_MAX + 1);
    localparam int TGL_W  = (TGL_RW < 1) ? 1 : TGL_RW;

    localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [TGL_W-1:0] left;
    logic [TGL_W-1:0] tgl_req;
    logic [CNT_W-1:0] gap_m1;

    // Toggle count is twice the saturated glitch count so the line ends at the target
    assign tgl_req = (int'(bounces) > BOUNCE_MAX) ? TGL_W'(2 * BOUNCE_MAX)
                                                  : TGL_W'(2 * int'(bounces));

`ifdef PBBOUNCE_FIXED_GAP_EN
    assign gap_m1 = CNT_W'(FIX_GAP - 1);
`else
    logic [GAP_W-1:0] g_raw;

    lfsr16 #(
        .OUT_W (GAP_W)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .value (g_raw)
    );

    // A zero sample would mean no hold at all, so it is treated as a gap of 1
    assign gap_m1 = (g_raw == '0) ? '0 : (CNT_W'(g_raw) - CNT_W'(1));
`endif

    // Sequencer: IDLE accepts a request, BOUNCE emits toggle pairs, SETTLE holds and pulses done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            left   <= '0;
            button <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (req) begin
                        button <= level;
                        busy   <= 1'b1;
                        left   <= tgl_req;
                        if (tgl_req != '0) begin
                            state <= ST_BOUNCE;
                            cnt   <= gap_m1;
                        end else begin
                            state <= ST_SETTLE;
                            cnt   <= SETTLE_M1;
                        end
                    end
                end
                ST_BOUNCE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        button <= ~button;
                        left   <= left - TGL_W'(1);
                        if (left == TGL_W'(1)) begin
                            state <= ST_SETTLE;
                            cnt   <= SETTLE_M1;
                        end else begin
                            cnt <= gap_m1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (done) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (cnt == '0) begin
                        done <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
